packet_eob_padder: RTL and testbench
====================================

# packet_eob_padder

Fixed-size packet padder placed directly downstream of the packet resizer, between the resizer's 32-bit sample output and the AXI wrapper's `s_axis_data` input in a packet-resizer NoC block. Packets are forwarded unchanged, except the final short packet of a burst. That packet is flagged by EOB in the CHDR header carried on `tuser`. It is extended with a programmable pad word up to the configured packet size. Downstream consumers therefore always see packets of exactly N samples.

## Interface
Parameters:
- `SR_PAD_SIZE`, default 130: settings address of the pad-size register; data[15:0] is N, in samples.
- `SR_PAD_CTRL`, default 131: settings address of the control register; data[31] is enable, data[30:0] is unused.
- `SR_PAD_VALUE`, default 132: settings address of the pad-word register; data[31:0] is the pad word.
- `DEFAULT_PKT_SIZE`, default 16: reset value of N.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `set_stb`  in  1  settings-bus strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data.
- `i_tdata`  in  32  input sample.
- `i_tuser`  in  128  input header: [127:64] is the CHDR header, [63:0] is the timestamp; EOB is bit 124.
- `i_tlast`  in  1  input end of packet.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  32  output sample.
- `o_tuser`  out  128  output header.
- `o_tlast`  out  1  output end of packet.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.
- `pad_active`  out  1  high while in state PAD.
- `pad_count`  out  16  count of pad words emitted since reset; wraps at 0xFFFF.

## Operation
- Registers:
  - Size register `n_reg` resets to `DEFAULT_PKT_SIZE`.
  - Enable resets to 0.
  - Pad word resets to 0.
  - All are written on `set_stb` with a matching `set_addr`.
- Per-packet latch:
  - On the first accepted beat of each packet, the block latches N (`n_lat`), enable (`en_lat`) and `i_tuser` (`hdr_lat`).
  - A setting changed mid-packet takes effect at the next packet.
- Beat counter `cnt` (16 bits):
  - Counts accepted output beats within the current packet.
  - Clears on any output beat with `tlast`.
  - Saturates at 0xFFFF.
- State PASS:
  - Forwards the input combinationally: `o_tdata`/`o_tuser`/`o_tvalid` follow the input, and `i_tready = o_tready`.
  - On an accepted input beat with `i_tlast=1`, `en_lat=1`, EOB set in `i_tuser`, `n_lat >= 2` and `cnt+1 < n_lat`:
    - output that beat with `o_tlast` forced to 0;
    - go to PAD.
  - Every other tlast beat passes through unchanged.
- State PAD:
  - `i_tready=0`, `o_tvalid=1`, `o_tdata` = pad word, `o_tuser` = `hdr_lat`.
  - `o_tlast=1` when `cnt == n_lat-1`.
  - On an accepted beat, `pad_count` increments.
  - When the `tlast` beat is accepted, go to PASS.
- Boundary cases:
  - Input packets longer than N are passed unmodified; no truncation.
  - N = 0 or 1 disables padding.
  - A non-EOB short packet is not padded.
  - The header length field is passed unchanged; the downstream framer recomputes it.

## Timing
- PASS latency is 0 cycles (combinational).
- PAD emits one word per cycle while `o_tready=1`.
- The PASS→PAD transition is registered, so the first pad word is offered in the cycle after the EOB beat is accepted.
- PAD→PASS: the next input beat can be accepted in the cycle after the pad `tlast` beat.
- AXI rules:
  - `o_tvalid`, once high in PAD, holds with stable data until accepted.
  - The input is never accepted while in PAD.
- A settings write in the same cycle as a first beat: the first beat latches the old value.
- Reset (asynchronous, including mid-PAD):
  - state returns to PASS;
  - `cnt`, `pad_count` and the latches clear;
  - `i_tready`, `o_tvalid`, `o_tlast` and `pad_active` are forced to 0 while `reset_n=0`;
  - `o_tdata` and `o_tuser` read 0.
- After reset release, normal PASS behaviour resumes on the next cycle.

## Structure
- Shared package: SR address constants, the CHDR `tuser` bit positions (EOB=124, has_time=125, length[111:96]), and the state enum {PASS, PAD}.
- The three settings registers use the existing `setting_reg` sub-module, one instance each.
- Everything else is a single module.

## Test plan
- N=8, enable=1, EOB packet of 3 samples (A,B,C), pad word 0xDEAD0000 -> output is A,B,C then 5 × 0xDEAD0000, `tlast` only on beat 8, `pad_count`=5.
- N=8, packets of 8 and 8 without EOB, then a 5-sample non-EOB packet -> all three pass bit-identical, `pad_count`=0.
- N=4, enable=0, EOB packet of 1 sample -> a single beat with `tlast`, no padding.
- EOB packet of 2 samples with N=6; N changed to 10 during sample 2; `o_tready` toggles 1,0 in PAD -> 4 pad words, stalled beats held stable; the next EOB 2-sample packet pads to 10.
- N=4, EOB packet of 9 samples -> 9 beats unmodified, no truncation, `cnt` clears.
- `reset_n` asserted on the 2nd pad word of an N=16 padding -> outputs 0 immediately; after release a new packet passes with `cnt` starting at 0.

Source files
------------

// File: rtl/packet_eob_padder_pkg.sv
// Shared constants and types for the EOB packet padder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package packet_eob_padder_pkg;

    localparam int DATA_W = 32;
    localparam int USER_W = 128;
    localparam int CNT_W  = 16;

    // Default settings-bus addresses of the three padder registers.
    localparam logic [7:0] SR_PAD_SIZE_DEF  = 8'd130;
    localparam logic [7:0] SR_PAD_CTRL_DEF  = 8'd131;
    localparam logic [7:0] SR_PAD_VALUE_DEF = 8'd132;

    localparam logic [15:0] DEFAULT_PKT_SIZE_DEF = 16'd16;

    // CHDR header bit positions within tuser ([127:64] header, [63:0] time).
    localparam int CHDR_EOB_BIT      = 124;
    localparam int CHDR_HAS_TIME_BIT = 125;
    localparam int CHDR_LEN_HI       = 111;
    localparam int CHDR_LEN_LO       = 96;

    // Enable flag position in the control register.
    localparam int CTRL_EN_BIT = 31;

    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } state_e;

    function automatic logic hdr_eob(input logic [USER_W-1:0] tuser);
        return tuser[CHDR_EOB_BIT];
    endfunction

endpackage

// File: rtl/packet_eob_padder_if.sv
// Sample stream bundle (data, CHDR tuser, last) with valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: tready from the slave side gates every beat.
interface packet_eob_padder_if;
    import packet_eob_padder_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tuser, input  tlast, input  tvalid, output tready);

endinterface

// File: rtl/setting_reg.sv
// Settings-bus register: captures a bit field of data when strobe hits MY_ADDR.
// Latency: value visible the cycle after the strobe.
// Backpressure: none, the settings bus is fire-and-forget.
module setting_reg #(
    parameter logic [7:0]       MY_ADDR  = 8'd0,
    parameter int               WIDTH    = 32,
    parameter int               LSB      = 0,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      data,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Only part of the data word may be used by a given register.
    logic unused_data;
    assign unused_data = ^data;

    // Load the selected field on an address match, otherwise hold.
    always_comb begin
        value_d = value_q;
        if (strobe && (addr == MY_ADDR)) begin
            value_d = data[LSB +: WIDTH];
        end
    end

    // Register state with asynchronous reset to the configured value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= AT_RESET;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/packet_eob_padder.sv
// Pads the short EOB-flagged last packet of a burst to N samples with a pad word.
// Latency: 0 cycles in pass-through; pad words start the cycle after the EOB beat.
// Backpressure: i_tready follows o_tready in pass-through, held low while padding.
module packet_eob_padder
    import packet_eob_padder_pkg::*;
#(
    parameter logic [7:0]  SR_PAD_SIZE      = SR_PAD_SIZE_DEF,
    parameter logic [7:0]  SR_PAD_CTRL      = SR_PAD_CTRL_DEF,
    parameter logic [7:0]  SR_PAD_VALUE     = SR_PAD_VALUE_DEF,
    parameter logic [15:0] DEFAULT_PKT_SIZE = DEFAULT_PKT_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    packet_eob_padder_if.slave    i_axis,
    packet_eob_padder_if.master   o_axis,
    output logic                  pad_active,
    output logic [CNT_W-1:0]      pad_count
);

    // Live settings.
    logic [15:0]       n_reg;
    logic [0:0]        en_reg;
    logic [DATA_W-1:0] pad_reg;

    setting_reg #(
        .MY_ADDR (SR_PAD_SIZE),
        .WIDTH   (16),
        .LSB     (0),
        .AT_RESET(DEFAULT_PKT_SIZE)
    ) u_size_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .strobe(set_stb),
        .addr  (set_addr),
        .data  (set_data),
        .value (n_reg)
    );

    setting_reg #(
        .MY_ADDR (SR_PAD_CTRL),
        .WIDTH   (1),
        .LSB     (CTRL_EN_BIT),
        .AT_RESET(1'b0)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .strobe(set_stb),
        .addr  (set_addr),
        .data  (set_data),
        .value (en_reg)
    );

    setting_reg #(
        .MY_ADDR (SR_PAD_VALUE),
        .WIDTH   (DATA_W),
        .LSB     (0),
        .AT_RESET('0)
    ) u_pad_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .strobe(set_stb),
        .addr  (set_addr),
        .data  (set_data),
        .value (pad_reg)
    );

    // State and per-packet latches.
    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [CNT_W-1:0]  pad_count_q, pad_count_d;
    logic              sop_q,       sop_d;
    logic [15:0]       n_lat_q,     n_lat_d;
    logic              en_lat_q,    en_lat_d;
    logic [USER_W-1:0] hdr_lat_q,   hdr_lat_d;
    logic [DATA_W-1:0] pad_lat_q,   pad_lat_d;

    // Combinational helpers and outputs.
    logic [15:0]       n_eff;
    logic              en_eff;
    logic [CNT_W-1:0]  cnt_inc;
    logic              start_pad;
    logic [DATA_W-1:0] o_tdata;
    logic [USER_W-1:0] o_tuser;
    logic              o_tlast;
    logic              o_tvalid;
    logic              i_tready;

    // Next-state, counters and output mux for the PASS/PAD machine.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pad_count_d = pad_count_q;
        sop_d       = sop_q;
        n_lat_d     = n_lat_q;
        en_lat_d    = en_lat_q;
        hdr_lat_d   = hdr_lat_q;
        pad_lat_d   = pad_lat_q;
        o_tdata     = '0;
        o_tuser     = '0;
        o_tlast     = 1'b0;
        o_tvalid    = 1'b0;
        i_tready    = 1'b0;
        start_pad   = 1'b0;

        // A single-beat packet must be judged on the settings it is about to
        // latch, so the first beat looks at the live registers.
        n_eff   = sop_q ? n_reg     : n_lat_q;
        en_eff  = sop_q ? en_reg[0] : en_lat_q;
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            PASS: begin
                o_tdata  = i_axis.tdata;
                o_tuser  = i_axis.tuser;
                o_tvalid = i_axis.tvalid;
                o_tlast  = i_axis.tlast;
                i_tready = o_axis.tready;

                start_pad = i_axis.tlast && en_eff && hdr_eob(i_axis.tuser) &&
                            (n_eff >= 16'd2) &&
                            (({1'b0, cnt_q} + 17'd1) < {1'b0, n_eff});
                if (start_pad) begin
                    o_tlast = 1'b0;
                end

                if (i_axis.tvalid && i_tready) begin
                    if (sop_q) begin
                        n_lat_d   = n_reg;
                        en_lat_d  = en_reg[0];
                        hdr_lat_d = i_axis.tuser;
                    end
                    sop_d = i_axis.tlast;
                    if (start_pad) begin
                        // Freeze the pad word so a stalled pad beat stays stable.
                        pad_lat_d = pad_reg;
                        cnt_d     = cnt_inc;
                        state_d   = PAD;
                    end else if (i_axis.tlast) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            PAD: begin
                o_tdata  = pad_lat_q;
                o_tuser  = hdr_lat_q;
                o_tvalid = 1'b1;
                o_tlast  = (cnt_q == (n_lat_q - 16'd1));
                i_tready = 1'b0;

                if (o_axis.tready) begin
                    pad_count_d = pad_count_q + 1'b1;
                    if (o_tlast) begin
                        cnt_d   = '0;
                        state_d = PASS;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            default: begin
                state_d = PASS;
            end
        endcase

        // Keep both sides of the handshake quiet while reset is held.
        if (!reset_n) begin
            o_tdata  = '0;
            o_tuser  = '0;
            o_tlast  = 1'b0;
            o_tvalid = 1'b0;
            i_tready = 1'b0;
        end
    end

    // State and latch registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PASS;
            cnt_q       <= '0;
            pad_count_q <= '0;
            sop_q       <= 1'b1;
            n_lat_q     <= '0;
            en_lat_q    <= 1'b0;
            hdr_lat_q   <= '0;
            pad_lat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pad_count_q <= pad_count_d;
            sop_q       <= sop_d;
            n_lat_q     <= n_lat_d;
            en_lat_q    <= en_lat_d;
            hdr_lat_q   <= hdr_lat_d;
            pad_lat_q   <= pad_lat_d;
        end
    end

    assign o_axis.tdata  = o_tdata;
    assign o_axis.tuser  = o_tuser;
    assign o_axis.tlast  = o_tlast;
    assign o_axis.tvalid = o_tvalid;
    assign i_axis.tready = i_tready;
    assign pad_active    = reset_n && (state_q == PAD);
    assign pad_count     = pad_count_q;

endmodule

// File: tb/tb_packet_eob_padder.sv
// Random and directed stimulus for the EOB padder against a packet-level model.
// Latency: n/a (testbench).
// Backpressure: output ready is driven always-on, randomly or toggling.
module tb_packet_eob_padder;
    import packet_eob_padder_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        pad_active;
    logic [15:0] pad_count;

    packet_eob_padder_if in_if();
    packet_eob_padder_if out_if();

    packet_eob_padder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .i_axis    (in_if),
        .o_axis    (out_if),
        .pad_active(pad_active),
        .pad_count (pad_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  d;
        logic [127:0] u;
        logic         l;
    } exp_t;

    exp_t         expq[$];
    int           n_err = 0;
    int           n_chk = 0;
    logic [15:0]  n_sh;
    logic         en_sh;
    logic [31:0]  pad_sh;
    logic [15:0]  exp_pad;
    int           rdy_mode;
    bit           gap_en;
    bit           mon_en;
    logic [31:0]  pkt_d[16];
    logic [127:0] pkt_u[16];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output consumer: ready pattern chosen by rdy_mode.
    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_if.tready = ($urandom_range(0, 3) != 0);
                2:       out_if.tready = ~out_if.tready;
                default: out_if.tready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard every accepted beat, check stalled beats hold.
    logic        stall_q = 1'b0;
    exp_t        prev_b;
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && mon_en) begin
            if (stall_q) begin
                check("hold_vld", out_if.tvalid, 1'b1);
                check("hold_beat", {out_if.tdata, out_if.tuser, out_if.tlast}, prev_b);
            end
            if (out_if.tvalid && out_if.tready) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    check("o_tdata", out_if.tdata, e.d);
                    check("o_tuser", out_if.tuser, e.u);
                    check("o_tlast", out_if.tlast, e.l);
                end
            end
            stall_q = out_if.tvalid && !out_if.tready;
            prev_b  = '{d: out_if.tdata, u: out_if.tuser, l: out_if.tlast};
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = v;
        @(posedge clk);
        #1;
        set_stb  = 1'b0;
        if (a == SR_PAD_SIZE_DEF)  n_sh   = v[15:0];
        if (a == SR_PAD_CTRL_DEF)  en_sh  = v[31];
        if (a == SR_PAD_VALUE_DEF) pad_sh = v;
    endtask

    task automatic fill(input int len, input bit eob);
        for (int i = 0; i < len; i++) begin
            pkt_d[i] = $urandom;
            pkt_u[i] = {$urandom, $urandom, $urandom, $urandom};
            pkt_u[i][CHDR_EOB_BIT] = eob;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [127:0] u, input logic last);
        bit ok = 1'b0;
        int wd = 0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tuser  = u;
        in_if.tlast  = last;
        while (!ok) begin
            @(negedge clk);
            ok = in_if.tready;
            @(posedge clk);
            #1;
            wd++;
            if (!ok && wd > 300) begin
                check("in_timeout", 1'b1, 1'b0);
                break;
            end
        end
        in_if.tvalid = 1'b0;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Model: a short EOB packet with padding enabled grows to exactly N beats
    // of which the tail is pad words carrying the first beat's header.
    task automatic send_pkt(input int len, input bit eob, input int mid_n);
        bit do_pad;
        do_pad = en_sh && eob && (n_sh >= 16'd2) && (len < int'(n_sh));
        for (int i = 0; i < len; i++) begin
            expq.push_back('{d: pkt_d[i], u: pkt_u[i], l: (i == len - 1) && !do_pad});
        end
        if (do_pad) begin
            for (int i = len; i < int'(n_sh); i++) begin
                expq.push_back('{d: pad_sh, u: pkt_u[0], l: (i == int'(n_sh) - 1)});
            end
            exp_pad = exp_pad + 16'(int'(n_sh) - len);
        end
        for (int i = 0; i < len; i++) begin
            send_beat(pkt_d[i], pkt_u[i], i == len - 1);
            if (i == 0 && mid_n >= 0) wr(SR_PAD_SIZE_DEF, 32'(mid_n));
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (expq.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_drain"}, expq.size(), 0);
        check({tag, "_pad_count"}, pad_count, exp_pad);
        expq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int t;
        logic [15:0] pc0;
        reset_n      = 1'b0;
        set_stb      = 1'b0;
        set_addr     = '0;
        set_data     = '0;
        rdy_mode     = 0;
        gap_en       = 1'b0;
        mon_en       = 1'b1;
        n_sh         = 16'd16;
        en_sh        = 1'b0;
        pad_sh       = '0;
        exp_pad      = '0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = 32'h1234_5678;
        in_if.tuser  = {4{32'hFFFF_FFFF}};
        in_if.tlast  = 1'b1;

        // Reset state with live input: everything gated to zero.
        #3;
        check("rst_i_tready", in_if.tready, 1'b0);
        check("rst_o_tvalid", out_if.tvalid, 1'b0);
        check("rst_o_tdata", out_if.tdata, 0);
        check("rst_o_tuser", out_if.tuser, 0);
        check("rst_o_tlast", out_if.tlast, 1'b0);
        check("rst_pad_active", pad_active, 1'b0);
        check("rst_pad_count", pad_count, 0);
        in_if.tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: N=8, EOB 3 samples -> 5 pad words.
        wr(SR_PAD_SIZE_DEF, 32'd8);
        wr(SR_PAD_CTRL_DEF, 32'h8000_0000);
        wr(SR_PAD_VALUE_DEF, 32'hDEAD_0000);
        fill(3, 1'b1);
        pkt_d[0] = 32'hA; pkt_d[1] = 32'hB; pkt_d[2] = 32'hC;
        send_pkt(3, 1'b1, -1);
        drain("t1");
        check("t1_pad5", pad_count, 16'd5);

        // 2: full packets and a short non-EOB packet pass unchanged.
        fill(8, 1'b0); send_pkt(8, 1'b0, -1);
        fill(8, 1'b0); send_pkt(8, 1'b0, -1);
        fill(5, 1'b0); send_pkt(5, 1'b0, -1);
        drain("t2");

        // 3: padding disabled, single-beat EOB packet.
        wr(SR_PAD_SIZE_DEF, 32'd4);
        wr(SR_PAD_CTRL_DEF, 32'h0000_0000);
        fill(1, 1'b1); send_pkt(1, 1'b1, -1);
        drain("t3");

        // 4: N changed mid-packet, toggling ready during padding.
        wr(SR_PAD_SIZE_DEF, 32'd6);
        wr(SR_PAD_CTRL_DEF, 32'h8000_0000);
        rdy_mode = 2;
        fill(2, 1'b1); send_pkt(2, 1'b1, 10);
        drain("t4a");
        fill(2, 1'b1); send_pkt(2, 1'b1, -1);
        drain("t4b");
        rdy_mode = 0;

        // 5: oversize EOB packet untouched, then the counter restarts cleanly.
        wr(SR_PAD_SIZE_DEF, 32'd4);
        fill(9, 1'b1); send_pkt(9, 1'b1, -1);
        fill(2, 1'b1); send_pkt(2, 1'b1, -1);
        drain("t5");

        // 6: asynchronous reset on the second pad word.
        wr(SR_PAD_SIZE_DEF, 32'd16);
        pc0 = pad_count;
        fill(3, 1'b1); send_pkt(3, 1'b1, -1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(pad_active && pad_count == pc0 + 16'd1) && t < 200);
        check("t6_reach_pad2", t < 200, 1'b1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t6_o_tvalid", out_if.tvalid, 1'b0);
        check("t6_o_tdata", out_if.tdata, 0);
        check("t6_o_tuser", out_if.tuser, 0);
        check("t6_o_tlast", out_if.tlast, 1'b0);
        check("t6_pad_active", pad_active, 1'b0);
        check("t6_pad_count", pad_count, 0);
        expq.delete();
        exp_pad = '0;
        n_sh    = 16'd16;
        en_sh   = 1'b0;
        pad_sh  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk);
        #1;
        wr(SR_PAD_SIZE_DEF, 32'd4);
        wr(SR_PAD_CTRL_DEF, 32'h8000_0000);
        wr(SR_PAD_VALUE_DEF, 32'hCAFE_F00D);
        fill(2, 1'b1); send_pkt(2, 1'b1, -1);
        drain("t6_after");

        // Randomized traffic with periodic settings changes.
        for (int p = 0; p < 40; p++) begin
            int len;
            bit eob;
            logic [31:0] cv;
            if (p % 5 == 0) begin
                drain("rnd");
                wr(SR_PAD_SIZE_DEF, 32'($urandom_range(0, 10)));
                cv = $urandom;
                cv[31] = ($urandom_range(0, 4) != 0);
                wr(SR_PAD_CTRL_DEF, cv);
                wr(SR_PAD_VALUE_DEF, $urandom);
                rdy_mode = $urandom_range(0, 2);
                gap_en   = $urandom_range(0, 1);
            end
            len = $urandom_range(1, 12);
            eob = $urandom_range(0, 1);
            fill(len, eob);
            send_pkt(len, eob, -1);
        end
        drain("rnd_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
